ddr3_bank_tracker: RTL and testbench
====================================

Name: ddr3_bank_tracker

Overview:
- Parametrised successor to the single-FSM DDR3 command decoder.
- Samples the DDR3 command bus every ck edge and tracks the global device state (init, ZQ, idle, refresh, self-refresh, power-down, MRS).
- Also tracks per-bank open/closed state, open row, and tRCD/tRP/tRFC/tMRD/tZQinit timing.
- Emits decoded read/write access strobes with bank/row/column, and flags protocol and timing violations. It sits between the DDR3 pin interface and the storage/data-path model.

Parameters:
- BA_BITS, 3, bank address width; NBANKS = 2**BA_BITS
- ADDR_BITS, 16, row address width
- COL_BITS, 11, column address width taken from addr[COL_BITS-1:0]
- T_RCD, 6, cycles from ACT to first legal RD/WR on that bank
- T_RP, 6, cycles from PRE (or auto-precharge) to bank closed
- T_RFC, 88, refresh busy cycles
- T_MRD, 4, MRS busy cycles
- T_ZQINIT, 512, ZQCL busy cycles during init
- CNT_W, 10, timing counter width; must hold the largest T_* value

Ports:
- ck  in  1  clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset
- cke  in  1  clock enable
- cs_n  in  1  chip select
- ras_n  in  1  row strobe
- cas_n  in  1  column strobe
- we_n  in  1  write enable
- ba  in  BA_BITS  bank address
- addr  in  ADDR_BITS  row/column address; addr[10] = auto-precharge / all-banks
- gstate  out  3  global state encoding
- bank_open  out  NBANKS  bit i = bank i OPEN, i.e. tRCD elapsed
- open_rows  out  NBANKS*ADDR_BITS  row held by bank i at slice i
- rd_strobe  out  1  one-cycle pulse, legal READ accepted
- wr_strobe  out  1  one-cycle pulse, legal WRITE accepted
- acc_bank  out  BA_BITS  bank of the accepted access
- acc_row  out  ADDR_BITS  row of the accepted access
- acc_col  out  COL_BITS  column of the accepted access
- acc_ap  out  1  accepted access carries auto-precharge
- err  out  1  one-cycle pulse, illegal command
- err_code  out  3  cause of the last err; holds until the next err

Behaviour:
- Reset: rst_n is sampled at the posedge of ck; there is no asynchronous path. Reset drives the following values, and the same values apply on reset mid-operation:
  - gstate = INIT
  - all banks CLOSED; bank counters 0
  - open_rows = 0, bank_open = 0
  - all strobes and err = 0
  - acc_* = 0, err_code = 0
- Command decode: cmd = {cke,cs_n,ras_n,cas_n,we_n}. Encodings:
  - ACT 10011, RD 10101, WR 10100, PRE 10010, REF 10001
  - ZQ 10110, MRS 10000, NOP 10111, DES 11xxx
  - SRE 00001, PDE 0x111 / 01xxx
- Global FSM, gstate encoding: INIT 0, ZQ_CAL 1, IDLE 2, REFRESH 3, SELF_REFR 4, PWR_DN 5, MRS 6.
  - INIT: ZQ → ZQ_CAL and load T_ZQINIT; other commands are ignored without error.
  - ZQ_CAL, REFRESH, MRS: the counter decrements each cycle. At 1 the FSM goes to IDLE on the next edge, so it spends exactly T_x cycles in the state.
  - A non-NOP/DES command in a busy state → err, code 1, and the command is dropped.
  - IDLE, REF: allowed only when every bank is CLOSED → REFRESH with T_RFC. Otherwise err code 2.
  - IDLE, SRE: same all-closed rule → SELF_REFR. Otherwise err code 2.
  - IDLE, MRS: same all-closed rule → MRS with T_MRD. Otherwise err code 2.
  - IDLE, ZQ: → ZQ_CAL with T_ZQINIT.
  - IDLE, cke low with NOP/DES → PWR_DN. Bank states and counters are frozen.
  - SELF_REFR and PWR_DN exit to IDLE on the first cycle with cke high and NOP/DES.
- Per-bank FSM, NBANKS copies, with states CLOSED, ACTIVATING, OPEN, PRECHARGING. It updates only while gstate is IDLE.
  - ACT to a CLOSED bank: latch addr into open_rows, go to ACTIVATING, load T_RCD. ACT to a non-CLOSED bank: err code 3.
  - ACTIVATING → OPEN when the counter expires. An ACT at edge n makes RD/WR legal at edge n+T_RCD.
  - RD/WR to an OPEN bank: pulse the strobe on the next cycle with acc_* set. If addr[10] = 1, set acc_ap and go to PRECHARGING with T_RP.
  - RD/WR to a bank that is not OPEN: err code 4 if ACTIVATING, code 5 otherwise. No strobe.
  - PRE with addr[10] = 0: the target bank, if OPEN or ACTIVATING, goes to PRECHARGING. PRE to a CLOSED bank is a legal NOP.
  - PRE with addr[10] = 1: applies to all banks. PRE to a bank already PRECHARGING does not reload its counter.
  - PRE to an ACTIVATING bank: err code 6, and the bank still precharges.
  - PRECHARGING → CLOSED after T_RP; open_rows for that bank keeps its value.
- Exactly one command is decoded per cycle. Bank counters expiring in the same cycle as a command are resolved first, so a command sees the updated bank state.
- A counter that wraps is a parameter error; it has no run-time check.

Decomposition:
- Package ddr3_cmd_pkg holds:
  - command encodings
  - gstate and bank-state localparams
  - err_code values: 1 busy, 2 bank open, 3 act-on-active, 4 tRCD, 5 closed access, 6 pre-during-act
- Sub-module ddr3_bank_fsm holds one bank's state, row register and CNT_W down-counter. It is instantiated NBANKS times by generate.

Test Plan:
- Reset, then ZQ → gstate 1 for 512 cycles, then gstate 2; DES during ZQ_CAL gives no err, RD during ZQ_CAL gives err code 1.
- ACT ba=3 row=0x1234, RD ba=3 col=0x40 issued 5 cycles later → err code 4. Same RD at 6 cycles → rd_strobe with acc_bank=3, acc_row=0x1234, acc_col=0x40.
- WR ba=2 with addr[10]=1 → wr_strobe and acc_ap=1; bank_open[2] drops; bank 2 CLOSED 6 cycles later; a second ACT before that gives err code 3.
- Banks 0 and 5 open, REF → err code 2; PRE with addr[10]=1, wait 6 cycles, REF → gstate 3 for 88 cycles, then IDLE.
- cke low with NOP while bank 1 open → PWR_DN; counters frozen; cke high → IDLE with bank 1 still open.
- rst_n low mid-REFRESH with banks open → next edge: gstate 0, bank_open 0, open_rows 0.

Source files
------------

// File: rtl/ddr3_cmd_pkg.sv
// Shared definitions for the DDR3 bank tracker.
//   - Raw 5-bit command encodings {cke, cs_n, ras_n, cas_n, we_n}
//   - Decoded command, global-state and bank-state enums
//   - err_code values
//   - decode_cmd(): maps a raw command vector to cmd_e
package ddr3_cmd_pkg;

   localparam logic [4:0] CMD_ACT = 5'b10011;
   localparam logic [4:0] CMD_RD  = 5'b10101;
   localparam logic [4:0] CMD_WR  = 5'b10100;
   localparam logic [4:0] CMD_PRE = 5'b10010;
   localparam logic [4:0] CMD_REF = 5'b10001;
   localparam logic [4:0] CMD_ZQ  = 5'b10110;
   localparam logic [4:0] CMD_MRS = 5'b10000;
   localparam logic [4:0] CMD_NOP = 5'b10111;
   localparam logic [4:0] CMD_SRE = 5'b00001;

   typedef enum logic [3:0] {
      C_ACT, C_RD, C_WR, C_PRE, C_REF, C_ZQ, C_MRS,
      C_NOP, C_DES, C_SRE, C_PDE, C_OTHER
   } cmd_e;

   typedef enum logic [2:0] {
      G_INIT      = 3'd0,
      G_ZQ_CAL    = 3'd1,
      G_IDLE      = 3'd2,
      G_REFRESH   = 3'd3,
      G_SELF_REFR = 3'd4,
      G_PWR_DN    = 3'd5,
      G_MRS       = 3'd6
   } gstate_e;

   typedef enum logic [1:0] {
      B_CLOSED,
      B_ACTIVATING,
      B_OPEN,
      B_PRECHARGING
   } bank_state_e;

   localparam logic [2:0] E_NONE       = 3'd0;
   localparam logic [2:0] E_BUSY       = 3'd1;
   localparam logic [2:0] E_BANK_OPEN  = 3'd2;
   localparam logic [2:0] E_ACT_ACTIVE = 3'd3;
   localparam logic [2:0] E_TRCD       = 3'd4;
   localparam logic [2:0] E_CLOSED_ACC = 3'd5;
   localparam logic [2:0] E_PRE_ACT    = 3'd6;

   // cke-low encodings: 00001 is self-refresh entry; any deselect or NOP
   // with cke low is power-down entry. Other cke-low vectors map to C_OTHER.
   function automatic cmd_e decode_cmd(input logic [4:0] c);
      cmd_e r;
      r = C_OTHER;
      casez (c)
         5'b11???: r = C_DES;
         CMD_NOP:  r = C_NOP;
         CMD_ACT:  r = C_ACT;
         CMD_RD:   r = C_RD;
         CMD_WR:   r = C_WR;
         CMD_PRE:  r = C_PRE;
         CMD_REF:  r = C_REF;
         CMD_ZQ:   r = C_ZQ;
         CMD_MRS:  r = C_MRS;
         CMD_SRE:  r = C_SRE;
         5'b0?111: r = C_PDE;
         5'b01???: r = C_PDE;
         default:  r = C_OTHER;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ddr3_bank_fsm.sv
// One DDR3 bank: state (CLOSED/ACTIVATING/OPEN/PRECHARGING), open-row
// register and a tRCD/tRP down-counter.
//   ck, rst_n     clock, synchronous active-low reset
//   en_i          bank may advance this cycle (device IDLE)
//   act_i         legal ACT to this bank (top guarantees bank is CLOSED)
//   ap_i          legal RD/WR with auto-precharge to this bank
//   pre_i         PRE addresses this bank (single or all-banks)
//   row_i         row address captured on ACT
//   state_o       registered bank state
//   eff_state_o   state after this cycle's counter expiry; commands are
//                 judged against this so an expiring timer takes effect first
//   row_o         held row address
module ddr3_bank_fsm
   import ddr3_cmd_pkg::*;
#(
   parameter int ADDR_BITS = 16,
   parameter int CNT_W     = 10,
   parameter int T_RCD     = 6,
   parameter int T_RP      = 6
)(
   input  logic                 ck,
   input  logic                 rst_n,
   input  logic                 en_i,
   input  logic                 act_i,
   input  logic                 ap_i,
   input  logic                 pre_i,
   input  logic [ADDR_BITS-1:0] row_i,
   output bank_state_e          state_o,
   output bank_state_e          eff_state_o,
   output logic [ADDR_BITS-1:0] row_o
);

   bank_state_e          state_q, state_d, eff_state;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] row_q, row_d;

   always_comb begin
      eff_state = state_q;
      if (en_i && cnt_q == CNT_W'(1)) begin
         if (state_q == B_ACTIVATING)       eff_state = B_OPEN;
         else if (state_q == B_PRECHARGING) eff_state = B_CLOSED;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      if (en_i) begin
         state_d = eff_state;
         if ((state_q == B_ACTIVATING || state_q == B_PRECHARGING) && cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
         if (act_i) begin
            state_d = B_ACTIVATING;
            cnt_d   = CNT_W'(T_RCD);
            row_d   = row_i;
         end else if (ap_i ||
                      (pre_i && (eff_state == B_OPEN || eff_state == B_ACTIVATING))) begin
            // A bank already precharging keeps its running counter.
            state_d = B_PRECHARGING;
            cnt_d   = CNT_W'(T_RP);
         end
      end
   end

   always_ff @(posedge ck) begin
      if (!rst_n) begin
         state_q <= B_CLOSED;
         cnt_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
      end
   end

   assign state_o     = state_q;
   assign eff_state_o = eff_state;
   assign row_o       = row_q;

endmodule

// File: rtl/ddr3_bank_tracker.sv
// DDR3 command-bus tracker: global device FSM, NBANKS bank FSMs, decoded
// access strobes and protocol/timing error flags.
//   ck, rst_n                 clock, synchronous active-low reset
//   cke,cs_n,ras_n,cas_n,we_n command bus
//   ba, addr                  bank / address (addr[10] = AP / all-banks)
//   gstate                    global state (0 INIT .. 6 MRS)
//   bank_open, open_rows      per-bank OPEN flag and held row
//   rd_strobe, wr_strobe      one-cycle pulse for an accepted access
//   acc_bank/row/col/ap       details of the last accepted access
//   err, err_code             one-cycle error pulse, code held until next err
module ddr3_bank_tracker
   import ddr3_cmd_pkg::*;
#(
   parameter int BA_BITS   = 3,
   parameter int ADDR_BITS = 16,
   parameter int COL_BITS  = 11,
   parameter int T_RCD     = 6,
   parameter int T_RP      = 6,
   parameter int T_RFC     = 88,
   parameter int T_MRD     = 4,
   parameter int T_ZQINIT  = 512,
   parameter int CNT_W     = 10,
   localparam int NBANKS   = 2**BA_BITS
)(
   input  logic                        ck,
   input  logic                        rst_n,
   input  logic                        cke,
   input  logic                        cs_n,
   input  logic                        ras_n,
   input  logic                        cas_n,
   input  logic                        we_n,
   input  logic [BA_BITS-1:0]          ba,
   input  logic [ADDR_BITS-1:0]        addr,
   output logic [2:0]                  gstate,
   output logic [NBANKS-1:0]           bank_open,
   output logic [NBANKS*ADDR_BITS-1:0] open_rows,
   output logic                        rd_strobe,
   output logic                        wr_strobe,
   output logic [BA_BITS-1:0]          acc_bank,
   output logic [ADDR_BITS-1:0]        acc_row,
   output logic [COL_BITS-1:0]         acc_col,
   output logic                        acc_ap,
   output logic                        err,
   output logic [2:0]                  err_code
);

   cmd_e                 cmd;
   logic                 nop_des;
   gstate_e              gstate_q, gstate_d;
   logic [CNT_W-1:0]     gcnt_q, gcnt_d;
   bank_state_e          bank_st  [NBANKS];
   bank_state_e          bank_eff [NBANKS];
   logic [ADDR_BITS-1:0] bank_row [NBANKS];
   logic [NBANKS-1:0]    act_v, ap_v, pre_v;
   logic                 bank_en, all_closed;
   bank_state_e          tgt_st;

   logic                 rd_q, rd_d, wr_q, wr_d, err_q, err_d, ap_q, ap_d;
   logic [2:0]           ecode_q, ecode_d;
   logic [BA_BITS-1:0]   abank_q, abank_d;
   logic [ADDR_BITS-1:0] arow_q, arow_d;
   logic [COL_BITS-1:0]  acol_q, acol_d;

   assign cmd     = decode_cmd({cke, cs_n, ras_n, cas_n, we_n});
   assign nop_des = (cmd == C_NOP) || (cmd == C_DES);
   // Banks (and their counters) only move while the device is IDLE.
   assign bank_en = (gstate_q == G_IDLE);
   assign tgt_st  = bank_eff[ba];

   always_comb begin
      all_closed = 1'b1;
      for (int i = 0; i < NBANKS; i++)
         if (bank_eff[i] != B_CLOSED) all_closed = 1'b0;
   end

   always_comb begin
      gstate_d = gstate_q;
      gcnt_d   = gcnt_q;
      act_v    = '0;
      ap_v     = '0;
      pre_v    = '0;
      rd_d     = 1'b0;
      wr_d     = 1'b0;
      err_d    = 1'b0;
      ecode_d  = ecode_q;
      abank_d  = abank_q;
      arow_d   = arow_q;
      acol_d   = acol_q;
      ap_d     = ap_q;
      case (gstate_q)
         G_INIT: begin
            if (cmd == C_ZQ) begin
               gstate_d = G_ZQ_CAL;
               gcnt_d   = CNT_W'(T_ZQINIT);
            end
         end
         G_ZQ_CAL, G_REFRESH, G_MRS: begin
            gcnt_d = gcnt_q - CNT_W'(1);
            if (gcnt_q == CNT_W'(1)) gstate_d = G_IDLE;
            if (!nop_des) begin
               err_d   = 1'b1;
               ecode_d = E_BUSY;
            end
         end
         G_IDLE: begin
            case (cmd)
               C_ACT: begin
                  if (tgt_st == B_CLOSED) act_v[ba] = 1'b1;
                  else begin
                     err_d   = 1'b1;
                     ecode_d = E_ACT_ACTIVE;
                  end
               end
               C_RD, C_WR: begin
                  if (tgt_st == B_OPEN) begin
                     rd_d    = (cmd == C_RD);
                     wr_d    = (cmd == C_WR);
                     abank_d = ba;
                     arow_d  = bank_row[ba];
                     acol_d  = addr[COL_BITS-1:0];
                     ap_d    = addr[10];
                     ap_v[ba] = addr[10];
                  end else begin
                     err_d   = 1'b1;
                     ecode_d = (tgt_st == B_ACTIVATING) ? E_TRCD : E_CLOSED_ACC;
                  end
               end
               C_PRE: begin
                  for (int i = 0; i < NBANKS; i++) begin
                     if (addr[10] || ba == BA_BITS'(i)) begin
                        pre_v[i] = 1'b1;
                        if (bank_eff[i] == B_ACTIVATING) begin
                           err_d   = 1'b1;
                           ecode_d = E_PRE_ACT;
                        end
                     end
                  end
               end
               C_REF, C_SRE, C_MRS: begin
                  if (!all_closed) begin
                     err_d   = 1'b1;
                     ecode_d = E_BANK_OPEN;
                  end else if (cmd == C_REF) begin
                     gstate_d = G_REFRESH;
                     gcnt_d   = CNT_W'(T_RFC);
                  end else if (cmd == C_MRS) begin
                     gstate_d = G_MRS;
                     gcnt_d   = CNT_W'(T_MRD);
                  end else begin
                     gstate_d = G_SELF_REFR;
                  end
               end
               C_ZQ: begin
                  gstate_d = G_ZQ_CAL;
                  gcnt_d   = CNT_W'(T_ZQINIT);
               end
               C_PDE:   gstate_d = G_PWR_DN;
               default: ;
            endcase
         end
         G_SELF_REFR, G_PWR_DN: begin
            if (nop_des) gstate_d = G_IDLE;
         end
         default: gstate_d = G_INIT;
      endcase
   end

   always_ff @(posedge ck) begin
      if (!rst_n) begin
         gstate_q <= G_INIT;
         gcnt_q   <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         err_q    <= 1'b0;
         ecode_q  <= E_NONE;
         abank_q  <= '0;
         arow_q   <= '0;
         acol_q   <= '0;
         ap_q     <= 1'b0;
      end else begin
         gstate_q <= gstate_d;
         gcnt_q   <= gcnt_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         err_q    <= err_d;
         ecode_q  <= ecode_d;
         abank_q  <= abank_d;
         arow_q   <= arow_d;
         acol_q   <= acol_d;
         ap_q     <= ap_d;
      end
   end

   for (genvar i = 0; i < NBANKS; i++) begin : g_bank
      ddr3_bank_fsm #(
         .ADDR_BITS (ADDR_BITS),
         .CNT_W     (CNT_W),
         .T_RCD     (T_RCD),
         .T_RP      (T_RP)
      ) u_bank (
         .ck          (ck),
         .rst_n       (rst_n),
         .en_i        (bank_en),
         .act_i       (act_v[i]),
         .ap_i        (ap_v[i]),
         .pre_i       (pre_v[i]),
         .row_i       (addr),
         .state_o     (bank_st[i]),
         .eff_state_o (bank_eff[i]),
         .row_o       (bank_row[i])
      );
      assign bank_open[i]                          = (bank_st[i] == B_OPEN);
      assign open_rows[i*ADDR_BITS +: ADDR_BITS]   = bank_row[i];
   end

   assign gstate    = gstate_q;
   assign rd_strobe = rd_q;
   assign wr_strobe = wr_q;
   assign err       = err_q;
   assign err_code  = ecode_q;
   assign acc_bank  = abank_q;
   assign acc_row   = arow_q;
   assign acc_col   = acol_q;
   assign acc_ap    = ap_q;

endmodule

// File: tb/tb_ddr3_bank_tracker.sv
// Directed bench for ddr3_bank_tracker with hand-computed expectations.
module tb_ddr3_bank_tracker;

   localparam logic [4:0] C_ACT = 5'b10011;
   localparam logic [4:0] C_RD  = 5'b10101;
   localparam logic [4:0] C_WR  = 5'b10100;
   localparam logic [4:0] C_PRE = 5'b10010;
   localparam logic [4:0] C_REF = 5'b10001;
   localparam logic [4:0] C_ZQ  = 5'b10110;
   localparam logic [4:0] C_NOP = 5'b10111;
   localparam logic [4:0] C_DES = 5'b11111;
   localparam logic [4:0] C_PDN = 5'b00111;
   localparam logic [4:0] C_PDD = 5'b01111;

   logic         ck = 1'b0;
   logic         rst_n, cke, cs_n, ras_n, cas_n, we_n;
   logic [2:0]   ba;
   logic [15:0]  addr;
   logic [2:0]   gstate;
   logic [7:0]   bank_open;
   logic [127:0] open_rows;
   logic         rd_strobe, wr_strobe, acc_ap, err;
   logic [2:0]   acc_bank, err_code;
   logic [15:0]  acc_row;
   logic [10:0]  acc_col;

   int n_cmp = 0;
   int n_mis = 0;

   ddr3_bank_tracker dut (
      .ck        (ck),
      .rst_n     (rst_n),
      .cke       (cke),
      .cs_n      (cs_n),
      .ras_n     (ras_n),
      .cas_n     (cas_n),
      .we_n      (we_n),
      .ba        (ba),
      .addr      (addr),
      .gstate    (gstate),
      .bank_open (bank_open),
      .open_rows (open_rows),
      .rd_strobe (rd_strobe),
      .wr_strobe (wr_strobe),
      .acc_bank  (acc_bank),
      .acc_row   (acc_row),
      .acc_col   (acc_col),
      .acc_ap    (acc_ap),
      .err       (err),
      .err_code  (err_code)
   );

   // clock
   always #5 ck = ~ck;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one command for exactly one rising edge, then return 1 time unit
   // after that edge so outputs reflect the command's effect.
   task automatic issue(input logic [4:0] c, input logic [2:0] b, input logic [15:0] a);
      {cke, cs_n, ras_n, cas_n, we_n} = c;
      ba   = b;
      addr = a;
      @(posedge ck);
      #1;
      {cke, cs_n, ras_n, cas_n, we_n} = C_NOP;
      ba   = '0;
      addr = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) issue(C_NOP, 3'd0, 16'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      {cke, cs_n, ras_n, cas_n, we_n} = C_NOP;
      ba   = '0;
      addr = '0;

      // reset state
      idle(2);
      check("rst_gstate", gstate, 0);
      check("rst_bank_open", bank_open, 0);
      check("rst_open_rows", open_rows, 0);
      check("rst_strobes", {rd_strobe, wr_strobe, err}, 0);
      check("rst_acc", {acc_bank, acc_row, acc_col, acc_ap}, 0);
      check("rst_err_code", err_code, 0);
      rst_n = 1'b1;

      // INIT ignores non-ZQ commands silently
      issue(C_RD, 3'd0, 16'h0);
      check("init_rd_ignored", {err, gstate}, {1'b0, 3'd0});

      // ZQ calibration: 512 cycles in state 1
      issue(C_ZQ, 3'd0, 16'h0);
      check("zq_enter", gstate, 1);
      issue(C_DES, 3'd0, 16'h0);
      check("zq_des_noerr", {err, gstate}, {1'b0, 3'd1});
      issue(C_RD, 3'd1, 16'h0);
      check("zq_rd_err", {err, err_code, gstate}, {1'b1, 3'd1, 3'd1});
      idle(509);
      check("zq_last_cycle", gstate, 1);
      check("err_pulse_cleared", {err, err_code}, {1'b0, 3'd1});
      idle(1);
      check("zq_to_idle", gstate, 2);

      // tRCD boundary on bank 3
      issue(C_ACT, 3'd3, 16'h1234);
      idle(4);
      issue(C_RD, 3'd3, 16'h0040);
      check("rd_early_err", {err, err_code, rd_strobe}, {1'b1, 3'd4, 1'b0});
      check("b3_not_open_yet", bank_open, 8'h00);
      issue(C_RD, 3'd3, 16'h0040);
      check("rd_ok_strobe", {rd_strobe, wr_strobe, err}, 3'b100);
      check("rd_ok_acc", {acc_bank, acc_row, acc_col, acc_ap}, {3'd3, 16'h1234, 11'h040, 1'b0});
      check("b3_open", bank_open, 8'h08);
      check("b3_row", open_rows[3*16 +: 16], 16'h1234);

      // write with auto-precharge on bank 2
      issue(C_ACT, 3'd2, 16'h0ABC);
      idle(6);
      check("b2_open", bank_open, 8'h0C);
      issue(C_WR, 3'd2, 16'h0407);
      check("wr_ap_strobe", {rd_strobe, wr_strobe, err}, 3'b010);
      check("wr_ap_acc", {acc_bank, acc_row, acc_col, acc_ap}, {3'd2, 16'h0ABC, 11'h407, 1'b1});
      check("b2_dropped", bank_open, 8'h08);
      idle(4);
      issue(C_ACT, 3'd2, 16'h0222);
      check("act_during_trp", {err, err_code}, {1'b1, 3'd3});
      check("b2_row_kept", open_rows[2*16 +: 16], 16'h0ABC);
      issue(C_ACT, 3'd2, 16'h0222);
      check("act_after_trp", err, 0);
      check("b2_row_new", open_rows[2*16 +: 16], 16'h0222);
      issue(C_RD, 3'd0, 16'h0010);
      check("rd_closed_bank", {err, err_code, rd_strobe}, {1'b1, 3'd5, 1'b0});

      // PRE to an activating bank
      issue(C_ACT, 3'd6, 16'h0066);
      issue(C_PRE, 3'd6, 16'h0000);
      check("pre_on_act", {err, err_code}, {1'b1, 3'd6});

      // REF with banks open, then PRE-all and tRP boundary
      issue(C_ACT, 3'd0, 16'h0100);
      issue(C_ACT, 3'd5, 16'h0500);
      idle(6);
      check("banks_0235_open", bank_open, 8'h2D);
      issue(C_REF, 3'd0, 16'h0);
      check("ref_banks_open", {err, err_code, gstate}, {1'b1, 3'd2, 3'd2});
      issue(C_PRE, 3'd0, 16'h0400);
      check("pre_all", {err, bank_open}, {1'b0, 8'h00});
      idle(4);
      issue(C_REF, 3'd0, 16'h0);
      check("ref_trp_early", {err, err_code, gstate}, {1'b1, 3'd2, 3'd2});
      issue(C_REF, 3'd0, 16'h0);
      check("ref_enter", {err, gstate}, {1'b0, 3'd3});
      issue(C_ACT, 3'd1, 16'h0);
      check("ref_busy_err", {err, err_code, gstate}, {1'b1, 3'd1, 3'd3});
      idle(86);
      check("ref_last_cycle", gstate, 3);
      idle(1);
      check("ref_to_idle", gstate, 2);

      // power-down freezes bank timing
      issue(C_ACT, 3'd1, 16'h0777);
      idle(5);
      issue(C_ACT, 3'd4, 16'h0444);
      check("b1_open", bank_open, 8'h02);
      issue(C_PDN, 3'd0, 16'h0);
      check("pd_enter", gstate, 5);
      for (int i = 0; i < 19; i++) issue((i % 2 == 0) ? C_PDD : C_PDN, 3'd0, 16'h0);
      check("pd_frozen", {gstate, bank_open}, {3'd5, 8'h02});
      issue(C_NOP, 3'd0, 16'h0);
      check("pd_exit", {gstate, bank_open}, {3'd2, 8'h02});
      idle(4);
      check("b4_still_act", bank_open, 8'h02);
      idle(1);
      check("b4_open_late", bank_open, 8'h12);

      // reset in the middle of REFRESH
      issue(C_PRE, 3'd0, 16'h0400);
      idle(6);
      issue(C_REF, 3'd0, 16'h0);
      idle(10);
      check("ref2_state", gstate, 3);
      check("b1_row_held", open_rows[1*16 +: 16], 16'h0777);
      rst_n = 1'b0;
      issue(C_NOP, 3'd0, 16'h0);
      rst_n = 1'b1;
      check("midrst_gstate", gstate, 0);
      check("midrst_banks", {bank_open, open_rows}, 0);
      check("midrst_regs", {err_code, acc_bank, acc_row, acc_col, acc_ap}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
